// File: rtl/vga_pkg.sv
// Shared VGA constants, colours and the object-slot record used by the renderer.
package vga_pkg;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned CMP_W   = 12;
    localparam int unsigned RGB_W   = 24;

    localparam logic [RGB_W-1:0] COL_BG     = 24'h000000;
    localparam logic [RGB_W-1:0] COL_PLAYER = 24'h00ff00;
    localparam logic [RGB_W-1:0] COL_OBJ    = 24'hff0000;

    typedef enum logic {SLOT_IDLE, SLOT_FALL} slot_state_t;

    typedef struct packed {
        slot_state_t        state;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    // Keep a left edge inside the visible area for an item of known width.
    function automatic logic [COORD_W-1:0] clamp_x(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] lim);
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational sync, active-area coordinates and frame markers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c,
    output logic               active_c,
    output logic               h_sync_c,
    output logic               v_sync_c,
    output logic               frame_start_c,
    output logic               frame_tick_c
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;

    logic [COORD_W-1:0] h_ctr;
    logic [COORD_W-1:0] v_ctr;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_in;
    logic               v_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_ctr <= '0;
            v_ctr <= '0;
        end else begin
            h_ctr <= h_wrap ? '0 : h_ctr + COORD_W'(1);
            if (h_wrap) begin
                v_ctr <= v_wrap ? '0 : v_ctr + COORD_W'(1);
            end
        end
    end

    always_comb begin
        h_wrap        = (h_ctr == COORD_W'(H_TOTAL - 1));
        v_wrap        = (v_ctr == COORD_W'(V_TOTAL - 1));
        h_in          = (h_ctr >= COORD_W'(H_START)) && (h_ctr < COORD_W'(H_START + H_ACTIVE));
        v_in          = (v_ctr >= COORD_W'(V_START)) && (v_ctr < COORD_W'(V_START + V_ACTIVE));
        x_c           = h_ctr - COORD_W'(H_START);
        y_c           = v_ctr - COORD_W'(V_START);
        active_c      = h_in && v_in;
        h_sync_c      = (h_ctr >= COORD_W'(H_SYNC));
        v_sync_c      = (v_ctr >= COORD_W'(V_SYNC));
        frame_start_c = (h_ctr == '0) && (v_ctr == '0);
        // Last visible pixel of the frame: objects step here.
        frame_tick_c  = active_c && (x_c == COORD_W'(H_ACTIVE - 1))
                                 && (y_c == COORD_W'(V_ACTIVE - 1));
    end

endmodule

// File: rtl/vga_object_renderer.sv
// Player plus falling-object sprite renderer on top of the VGA raster generator.
module vga_object_renderer
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned N_OBJ     = 4,
    parameter int unsigned OBJ_W     = 50,
    parameter int unsigned OBJ_H     = 50,
    parameter int unsigned PLY_W     = 40,
    parameter int unsigned PLY_H     = 50,
    parameter int unsigned FALL_STEP = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] player_x,
    input  logic               spawn_valid,
    input  logic [COORD_W-1:0] spawn_x,
    output logic               spawn_ready,
    output logic               hit,
    output logic [N_OBJ-1:0]   obj_active,
    output logic               frame_start,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank_n,
    output logic               sync_n,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue
);

    localparam logic [CMP_W-1:0]   OBJ_W_C   = CMP_W'(OBJ_W);
    localparam logic [CMP_W-1:0]   OBJ_H_C   = CMP_W'(OBJ_H);
    localparam logic [CMP_W-1:0]   PLY_W_C   = CMP_W'(PLY_W);
    localparam logic [CMP_W-1:0]   PLY_H_C   = CMP_W'(PLY_H);
    localparam logic [CMP_W-1:0]   PLY_TOP   = CMP_W'(V_ACTIVE - PLY_H);
    localparam logic [CMP_W-1:0]   STEP_C    = CMP_W'(FALL_STEP);
    localparam logic [CMP_W-1:0]   V_ACT_C   = CMP_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] OBJ_X_MAX = COORD_W'(H_ACTIVE - OBJ_W);
    localparam logic [COORD_W-1:0] PLY_X_MAX = COORD_W'(H_ACTIVE - PLY_W);

    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    logic               active_c;
    logic               h_sync_c;
    logic               v_sync_c;
    logic               frame_start_c;
    logic               frame_tick;

    vga_timing_gen #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .x_c          (x_c),
        .y_c          (y_c),
        .active_c     (active_c),
        .h_sync_c     (h_sync_c),
        .v_sync_c     (v_sync_c),
        .frame_start_c(frame_start_c),
        .frame_tick_c (frame_tick)
    );

    slot_t [N_OBJ-1:0] slots;
    slot_t [N_OBJ-1:0] slots_nxt;
    logic  [N_OBJ-1:0] is_fall;
    logic  [N_OBJ-1:0] collide;
    logic  [N_OBJ-1:0] covers;
    logic  [N_OBJ-1:0] exits;
    logic  [N_OBJ-1:0] alloc;
    logic              any_idle;
    logic              run_en;
    logic              accept;
    logic [CMP_W-1:0]  ply_x;
    logic [CMP_W-1:0]  px;
    logic [CMP_W-1:0]  py;
    logic              ply_pix;
    logic [RGB_W-1:0]  pix_col;

    assign ply_x = CMP_W'(clamp_x(player_x, PLY_X_MAX));
    assign px    = CMP_W'(x_c);
    assign py    = CMP_W'(y_c);

    // Per-slot geometry, evaluated at 12 bits so right/bottom edges never wrap.
    for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
        logic [CMP_W-1:0] ox;
        logic [CMP_W-1:0] oy;
        assign ox         = CMP_W'(slots[i].x);
        assign oy         = CMP_W'(slots[i].y);
        assign is_fall[i] = (slots[i].state == SLOT_FALL);
        assign collide[i] = is_fall[i] && (ox < ply_x + PLY_W_C) && (ply_x < ox + OBJ_W_C)
                                       && (oy < PLY_TOP + PLY_H_C) && (PLY_TOP < oy + OBJ_H_C);
        assign covers[i]  = is_fall[i] && (px >= ox) && (px < ox + OBJ_W_C)
                                       && (py >= oy) && (py < oy + OBJ_H_C);
        assign exits[i]   = (oy + STEP_C) >= V_ACT_C;
    end

    // Lowest-index idle slot gets the next spawn.
    always_comb begin
        alloc    = '0;
        any_idle = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (!is_fall[i] && !any_idle) begin
                alloc[i] = 1'b1;
                any_idle = 1'b1;
            end
        end
    end

    assign spawn_ready = run_en && any_idle && !frame_tick;
    assign accept      = spawn_valid && spawn_ready;
    assign obj_active  = is_fall;
    assign sync_n      = 1'b0;

    // Slot next-state: frame step and spawn are exclusive because ready drops on the tick.
    always_comb begin
        slots_nxt = slots;
        for (int i = 0; i < N_OBJ; i++) begin
            if (frame_tick && is_fall[i]) begin
                if (collide[i]) begin
                    slots_nxt[i].state = SLOT_IDLE;
                end else begin
                    slots_nxt[i].y = slots[i].y + COORD_W'(FALL_STEP);
                    if (exits[i]) begin
                        slots_nxt[i].state = SLOT_IDLE;
                    end
                end
            end else if (accept && alloc[i]) begin
                slots_nxt[i].state = SLOT_FALL;
                slots_nxt[i].x     = clamp_x(spawn_x, OBJ_X_MAX);
                slots_nxt[i].y     = '0;
            end
        end
    end

    always_comb begin
        ply_pix = (px >= ply_x) && (px < ply_x + PLY_W_C) && (py >= PLY_TOP) && (py < PLY_TOP + PLY_H_C);
        pix_col = COL_BG;
        if (active_c) begin
            if (|covers) begin
                pix_col = COL_OBJ;
            end else if (ply_pix) begin
                pix_col = COL_PLAYER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                slots[i].state <= SLOT_IDLE;
                slots[i].x     <= '0;
                slots[i].y     <= '0;
            end
            run_en             <= 1'b0;
            hit                <= 1'b0;
            frame_start        <= 1'b0;
            h_sync             <= 1'b0;
            v_sync             <= 1'b0;
            blank_n            <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            slots              <= slots_nxt;
            run_en             <= 1'b1;
            hit                <= frame_tick && (|collide);
            frame_start        <= frame_start_c;
            h_sync             <= h_sync_c;
            v_sync             <= v_sync_c;
            blank_n            <= active_c;
            {red, green, blue} <= pix_col;
        end
    end

endmodule

// File: tb/tb_vga_object_renderer.sv
// Scoreboard bench: a behavioural raster/slot model predicts every registered output cycle by cycle.
module tb_vga_object_renderer;

    localparam int H_SYNC = 4, H_BACK = 3, H_ACTIVE = 40, H_FRONT = 2;
    localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 24, V_FRONT = 2;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int N_OBJ = 4, OBJ_W = 6, OBJ_H = 6, PLY_W = 5, PLY_H = 6, FALL_STEP = 2;
    localparam int PLY_TOP = V_ACTIVE - PLY_H;

    typedef struct packed {
        logic [4:0]  sync;
        logic [23:0] rgb;
        logic [5:0]  ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] player_x;
    logic        spawn_valid;
    logic [10:0] spawn_x;
    logic        spawn_ready;
    logic        hit;
    logic [3:0]  obj_active;
    logic        frame_start, h_sync, v_sync, blank_n, sync_n;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    vga_object_renderer #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
        .N_OBJ(N_OBJ), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .PLY_W(PLY_W), .PLY_H(PLY_H),
        .FALL_STEP(FALL_STEP)
    ) dut (
        .clk(clk), .reset(reset), .player_x(player_x),
        .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_ready(spawn_ready),
        .hit(hit), .obj_active(obj_active), .frame_start(frame_start),
        .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n), .sync_n(sync_n),
        .red(red), .green(green), .blue(blue)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int   mh, mv;
    bit   men;
    bit   mfall [N_OBJ];
    int   mx [N_OBJ];
    int   my [N_OBJ];
    exp_t sb [$];

    function automatic bit tick_now();
        int ax = mh - (H_SYNC + H_BACK);
        int ay = mv - (V_SYNC + V_BACK);
        return (ax == H_ACTIVE - 1) && (ay == V_ACTIVE - 1);
    endfunction

    function automatic int free_slots();
        int n = 0;
        for (int i = 0; i < N_OBJ; i++) if (!mfall[i]) n++;
        return n;
    endfunction

    function automatic logic [3:0] active_bits();
        logic [3:0] b = '0;
        for (int i = 0; i < N_OBJ; i++) b[i] = mfall[i];
        return b;
    endfunction

    task automatic model_step();
        exp_t e;
        int   ax, ay, pxc, sxc;
        bit   act, tick, rdy, coll, obj_px, ply_px, took;
        e = '0;
        if (!reset) begin
            mh = 0; mv = 0; men = 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                mfall[i] = 1'b0; mx[i] = 0; my[i] = 0;
            end
            sb.push_back(e);
            return;
        end
        ax   = mh - (H_SYNC + H_BACK);
        ay   = mv - (V_SYNC + V_BACK);
        act  = (ax >= 0) && (ax < H_ACTIVE) && (ay >= 0) && (ay < V_ACTIVE);
        tick = act && tick_now();
        pxc  = (int'(player_x) > H_ACTIVE - PLY_W) ? H_ACTIVE - PLY_W : int'(player_x);
        sxc  = (int'(spawn_x) > H_ACTIVE - OBJ_W) ? H_ACTIVE - OBJ_W : int'(spawn_x);
        rdy  = men && !tick && (free_slots() > 0);
        obj_px = 1'b0;
        for (int i = 0; i < N_OBJ; i++)
            if (mfall[i] && ax >= mx[i] && ax < mx[i] + OBJ_W && ay >= my[i] && ay < my[i] + OBJ_H)
                obj_px = 1'b1;
        ply_px = (ax >= pxc) && (ax < pxc + PLY_W) && (ay >= PLY_TOP) && (ay < V_ACTIVE);
        e.sync = {(mh == 0) && (mv == 0), mh >= H_SYNC, mv >= V_SYNC, act, 1'b0};
        e.rgb  = !act ? 24'h0 : obj_px ? 24'hff0000 : ply_px ? 24'h00ff00 : 24'h0;
        coll = 1'b0;
        if (tick) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (!mfall[i]) continue;
                if (mx[i] < pxc + PLY_W && pxc < mx[i] + OBJ_W && my[i] < V_ACTIVE && PLY_TOP < my[i] + OBJ_H) begin
                    mfall[i] = 1'b0;
                    coll     = 1'b1;
                end else begin
                    my[i] += FALL_STEP;
                    if (my[i] >= V_ACTIVE) mfall[i] = 1'b0;
                end
            end
        end else if (spawn_valid && rdy) begin
            took = 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                if (!mfall[i] && !took) begin
                    mfall[i] = 1'b1; mx[i] = sxc; my[i] = 0; took = 1'b1;
                end
            end
        end
        if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        men   = 1'b1;
        e.ctl = {tick && coll, active_bits(), (free_slots() > 0) && !tick_now()};
        sb.push_back(e);
    endtask

    // Frame statistics gathered from sampled outputs
    int cyc = 0, last_fs = 0, fs_gap = 0, hit_n = 0;
    int cur_hs, cur_vs, cur_red, cur_green;
    int last_hs, last_vs, last_red, last_green;

    task automatic cycle();
        exp_t e, got;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        got.sync = {frame_start, h_sync, v_sync, blank_n, sync_n};
        got.rgb  = {red, green, blue};
        got.ctl  = {hit, obj_active, spawn_ready};
        check_eq("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("sync", 64'(got.sync), 64'(e.sync));
            check_eq("rgb", 64'(got.rgb), 64'(e.rgb));
            check_eq("ctl", 64'(got.ctl), 64'(e.ctl));
        end
        if (frame_start) begin
            fs_gap = cyc - last_fs; last_fs = cyc;
            last_hs = cur_hs; last_vs = cur_vs; last_red = cur_red; last_green = cur_green;
            cur_hs = 0; cur_vs = 0; cur_red = 0; cur_green = 0;
        end
        if (!h_sync) cur_hs++;
        if (!v_sync) cur_vs++;
        if (red == 8'hff) cur_red++;
        if (green == 8'hff) cur_green++;
        if (hit) hit_n++;
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            cycle();
            if (frame_start) seen = 1'b1;
        end
        check_eq("fs_timeout", 64'(seen), 64'd1);
    endtask

    task automatic spawn(input int x);
        spawn_valid = 1'b1;
        spawn_x     = 11'(x);
        cycle();
        spawn_valid = 1'b0;
    endtask

    initial begin
        bit hit_tick;
        cur_hs = 0; cur_vs = 0; cur_red = 0; cur_green = 0;
        last_hs = 0; last_vs = 0; last_red = 0; last_green = 0;
        reset = 1'b0; player_x = 11'd20; spawn_valid = 1'b0; spawn_x = '0;
        repeat (3) cycle();
        check_eq("rst_ready", 64'(spawn_ready), 64'd0);
        reset = 1'b1;
        cycle();
        check_eq("ready_after_rst", 64'(spawn_ready), 64'd1);

        // Idle frame: only the player is drawn
        wait_fs();
        check_eq("fs_period", 64'(fs_gap), 64'(FRAME));
        check_eq("hs_low", 64'(last_hs), 64'(H_SYNC * V_TOTAL));
        check_eq("vs_low", 64'(last_vs), 64'(V_SYNC * H_TOTAL));
        check_eq("idle_green", 64'(last_green), 64'(PLY_W * PLY_H));
        check_eq("idle_red", 64'(last_red), 64'd0);

        // Spawn during vertical blanking is drawn the same frame
        spawn(10);
        check_eq("spawn_slot0", 64'(obj_active), 64'h1);
        wait_fs();
        check_eq("red_first_frame", 64'(last_red), 64'(OBJ_W * OBJ_H));

        // Clamped spawn, then fill every slot
        spawn(100);
        spawn(18);
        spawn(0);
        check_eq("full_ready", 64'(spawn_ready), 64'd0);
        spawn(5);
        check_eq("full_ignore", 64'(obj_active), 64'hf);
        wait_fs();
        check_eq("red_four", 64'(last_red), 64'(4 * OBJ_W * OBJ_H));

        // Let objects fall; one lands on the player
        for (int f = 0; f < 20 && obj_active != 4'h0; f++) wait_fs();
        check_eq("all_retired", 64'(obj_active), 64'h0);
        check_eq("hit_count", 64'(hit_n), 64'd1);
        check_eq("ready_back", 64'(spawn_ready), 64'd1);

        // Request held across the frame tick
        hit_tick = 1'b0;
        for (int k = 0; k < 2 * FRAME && !hit_tick; k++) begin
            if (tick_now()) hit_tick = 1'b1;
            else cycle();
        end
        check_eq("tick_found", 64'(hit_tick), 64'd1);
        check_eq("ready_low_tick", 64'(spawn_ready), 64'd0);
        spawn_valid = 1'b1; spawn_x = 11'd7;
        cycle();
        check_eq("tick_hold_rej", 64'(obj_active), 64'h0);
        cycle();
        spawn_valid = 1'b0;
        check_eq("tick_hold_acc", 64'(obj_active), 64'h1);

        // Mid-frame reset clears everything
        spawn(30);
        repeat (600) cycle();
        check_eq("pre_rst_obj", 64'(obj_active), 64'h3);
        reset = 1'b0;
        cycle();
        check_eq("rst_obj", 64'(obj_active), 64'h0);
        check_eq("rst_out", 64'({h_sync, v_sync, blank_n, frame_start, hit, red, green, blue}), 64'h0);
        cycle();
        reset = 1'b1;
        cycle();
        check_eq("rst_rel_fs", 64'(frame_start), 64'd1);
        wait_fs();
        check_eq("rst_fs_period", 64'(fs_gap), 64'(FRAME));
        check_eq("rst_red", 64'(last_red), 64'd0);
        check_eq("rst_green", 64'(last_green), 64'(PLY_W * PLY_H));
        check_eq("rst_hits", 64'(hit_n), 64'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
